// File: rtl/plan_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plan_sel_pkg
// Purpose  : Shared types, widths and the plan score function for the
//            plan selection sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package plan_sel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EVAL  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int VAL_W       = 6;
   localparam int WGT_W       = 3;
   localparam int SCORE_W     = 16;
   localparam int PROD_W      = VAL_W + WGT_W;
   localparam int RAW_SCORE_W = PROD_W + 1;

   // talk*w_talk + data*w_data; both products fit in 9 bits, the sum in 10
   function automatic logic [RAW_SCORE_W-1:0] calc_score(
      input logic [VAL_W-1:0] talk,
      input logic [VAL_W-1:0] data,
      input logic [WGT_W-1:0] wt,
      input logic [WGT_W-1:0] wd
   );
      logic [PROD_W-1:0] p_talk;
      logic [PROD_W-1:0] p_data;
      p_talk = {{WGT_W{1'b0}}, talk} * {{VAL_W{1'b0}}, wt};
      p_data = {{WGT_W{1'b0}}, data} * {{VAL_W{1'b0}}, wd};
      return {1'b0, p_talk} + {1'b0, p_data};
   endfunction

endpackage
`default_nettype wire

// File: rtl/plan_select_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : plan_select_sequencer_if
// Purpose  : User request, plan-table fetch handshake and result bundle.
//            slave = sequencer side, master = requester / plan-table side.
// Revision : 1.0 - initial release
// ============================================================================
interface plan_select_sequencer_if #(
   parameter int IDX_W = 3
) ();
   import plan_sel_pkg::*;

   logic                start;
   logic [VAL_W-1:0]    budget;
   logic [VAL_W-1:0]    avg_talk;
   logic [VAL_W-1:0]    avg_data;
   logic [WGT_W-1:0]    w_talk;
   logic [WGT_W-1:0]    w_data;
   logic                plan_req;
   logic [IDX_W-1:0]    plan_idx;
   logic                plan_vld;
   logic [VAL_W-1:0]    plan_price;
   logic [VAL_W-1:0]    plan_talk;
   logic [VAL_W-1:0]    plan_data;
   logic                busy;
   logic                done;
   logic [IDX_W-1:0]    best_idx;
   logic [SCORE_W-1:0]  best_score;
   logic                none_ok;

   modport slave (
      input  start, budget, avg_talk, avg_data, w_talk, w_data,
      input  plan_vld, plan_price, plan_talk, plan_data,
      output plan_req, plan_idx, busy, done, best_idx, best_score, none_ok
   );

   modport master (
      output start, budget, avg_talk, avg_data, w_talk, w_data,
      output plan_vld, plan_price, plan_talk, plan_data,
      input  plan_req, plan_idx, busy, done, best_idx, best_score, none_ok
   );

endinterface
`default_nettype wire

// File: rtl/plan_select_sequencer_eval.sv
`default_nettype none
// ============================================================================
// Module   : plan_eval
// Purpose  : Shared eligibility check and score for one plan against the
//            captured user profile. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module plan_eval
   import plan_sel_pkg::*;
(
   input  wire logic [VAL_W-1:0]       price,
   input  wire logic [VAL_W-1:0]       talk,
   input  wire logic [VAL_W-1:0]       data,
   input  wire logic [VAL_W-1:0]       budget,
   input  wire logic [VAL_W-1:0]       avg_talk,
   input  wire logic [VAL_W-1:0]       avg_data,
   input  wire logic [WGT_W-1:0]       w_talk,
   input  wire logic [WGT_W-1:0]       w_data,
   output logic                        eligible,
   output logic [RAW_SCORE_W-1:0]      score
);

   // Plan is usable if affordable and covers both usage averages
   always_comb begin
      eligible = (price <= budget) && (talk >= avg_talk) && (data >= avg_data);
      score    = calc_score(talk, data, w_talk, w_data);
   end

endmodule
`default_nettype wire

// File: rtl/plan_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : plan_select_sequencer
// Purpose  : Scans the plan table one entry at a time through a single
//            eligibility/score unit, tracking the best eligible plan and the
//            cheapest plan as fallback.
// Revision : 1.0 - initial release
// ============================================================================
module plan_select_sequencer
   import plan_sel_pkg::*;
#(
   parameter int NUM_PLANS = 5,
   parameter int IDX_W     = 3
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   plan_select_sequencer_if.slave       bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLANS - 1);

   state_e                  state_q,        state_d;
   logic [IDX_W-1:0]        idx_q,          idx_d;
   logic [VAL_W-1:0]        budget_q,       budget_d;
   logic [VAL_W-1:0]        avg_talk_q,     avg_talk_d;
   logic [VAL_W-1:0]        avg_data_q,     avg_data_d;
   logic [WGT_W-1:0]        w_talk_q,       w_talk_d;
   logic [WGT_W-1:0]        w_data_q,       w_data_d;
   logic [VAL_W-1:0]        price_q,        price_d;
   logic [VAL_W-1:0]        talk_q,         talk_d;
   logic [VAL_W-1:0]        data_q,         data_d;
   logic                    any_ok_q,       any_ok_d;
   logic [IDX_W-1:0]        run_idx_q,      run_idx_d;
   logic [RAW_SCORE_W-1:0]  run_score_q,    run_score_d;
   logic [IDX_W-1:0]        cheap_idx_q,    cheap_idx_d;
   logic [VAL_W-1:0]        cheap_price_q,  cheap_price_d;
   logic                    plan_req_q,     plan_req_d;
   logic                    busy_q,         busy_d;
   logic                    done_q,         done_d;
   logic [IDX_W-1:0]        best_idx_q,     best_idx_d;
   logic [SCORE_W-1:0]      best_score_q,   best_score_d;
   logic                    none_ok_q,      none_ok_d;

   logic                    eval_ok;
   logic [RAW_SCORE_W-1:0]  eval_score;

   plan_eval u_eval (
      .price    (price_q),
      .talk     (talk_q),
      .data     (data_q),
      .budget   (budget_q),
      .avg_talk (avg_talk_q),
      .avg_data (avg_data_q),
      .w_talk   (w_talk_q),
      .w_data   (w_data_q),
      .eligible (eval_ok),
      .score    (eval_score)
   );

   // Next-state, tracker and registered-output computation
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      budget_d      = budget_q;
      avg_talk_d    = avg_talk_q;
      avg_data_d    = avg_data_q;
      w_talk_d      = w_talk_q;
      w_data_d      = w_data_q;
      price_d       = price_q;
      talk_d        = talk_q;
      data_d        = data_q;
      any_ok_d      = any_ok_q;
      run_idx_d     = run_idx_q;
      run_score_d   = run_score_q;
      cheap_idx_d   = cheap_idx_q;
      cheap_price_d = cheap_price_q;
      plan_req_d    = plan_req_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      best_idx_d    = best_idx_q;
      best_score_d  = best_score_q;
      none_ok_d     = none_ok_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               budget_d      = bus.budget;
               avg_talk_d    = bus.avg_talk;
               avg_data_d    = bus.avg_data;
               w_talk_d      = bus.w_talk;
               w_data_d      = bus.w_data;
               any_ok_d      = 1'b0;
               run_idx_d     = '0;
               run_score_d   = '0;
               cheap_idx_d   = '0;
               cheap_price_d = {VAL_W{1'b1}};
               idx_d         = '0;
               busy_d        = 1'b1;
               plan_req_d    = 1'b1;
               state_d       = FETCH;
            end
         end
         FETCH: begin
            if (bus.plan_vld) begin
               price_d    = bus.plan_price;
               talk_d     = bus.plan_talk;
               data_d     = bus.plan_data;
               plan_req_d = 1'b0;
               state_d    = EVAL;
            end
         end
         EVAL: begin
            // Strict greater-than keeps the lowest index on score ties
            if (eval_ok && (!any_ok_q || (eval_score > run_score_q))) begin
               any_ok_d    = 1'b1;
               run_idx_d   = idx_q;
               run_score_d = eval_score;
            end
            // Plan 0 always seeds the cheapest tracker, even at price 63
            if ((idx_q == '0) || (price_q < cheap_price_q)) begin
               cheap_idx_d   = idx_q;
               cheap_price_d = price_q;
            end
            if (idx_q == LAST_IDX) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
               if (any_ok_d) begin
                  best_idx_d   = run_idx_d;
                  best_score_d = SCORE_W'(run_score_d);
                  none_ok_d    = 1'b0;
               end else begin
                  best_idx_d   = cheap_idx_d;
                  best_score_d = '0;
                  none_ok_d    = 1'b1;
               end
            end else begin
               idx_d      = idx_q + IDX_W'(1);
               plan_req_d = 1'b1;
               state_d    = FETCH;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         budget_q      <= '0;
         avg_talk_q    <= '0;
         avg_data_q    <= '0;
         w_talk_q      <= '0;
         w_data_q      <= '0;
         price_q       <= '0;
         talk_q        <= '0;
         data_q        <= '0;
         any_ok_q      <= 1'b0;
         run_idx_q     <= '0;
         run_score_q   <= '0;
         cheap_idx_q   <= '0;
         cheap_price_q <= {VAL_W{1'b1}};
         plan_req_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         best_idx_q    <= '0;
         best_score_q  <= '0;
         none_ok_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         budget_q      <= budget_d;
         avg_talk_q    <= avg_talk_d;
         avg_data_q    <= avg_data_d;
         w_talk_q      <= w_talk_d;
         w_data_q      <= w_data_d;
         price_q       <= price_d;
         talk_q        <= talk_d;
         data_q        <= data_d;
         any_ok_q      <= any_ok_d;
         run_idx_q     <= run_idx_d;
         run_score_q   <= run_score_d;
         cheap_idx_q   <= cheap_idx_d;
         cheap_price_q <= cheap_price_d;
         plan_req_q    <= plan_req_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         best_idx_q    <= best_idx_d;
         best_score_q  <= best_score_d;
         none_ok_q     <= none_ok_d;
      end
   end

   assign bus.plan_req   = plan_req_q;
   assign bus.plan_idx   = idx_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.best_idx   = best_idx_q;
   assign bus.best_score = best_score_q;
   assign bus.none_ok    = none_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_plan_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_plan_select_sequencer
// Purpose  : Directed self-checking bench for plan_select_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plan_select_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   // Plan table model and stall injection
   logic [5:0] tp [8];
   logic [5:0] tt [8];
   logic [5:0] td [8];
   logic [2:0] stall_idx = 3'd7;
   int         stall_len = 0;
   int         stall_cnt = 0;
   logic       stall_clr = 1'b0;

   plan_select_sequencer_if #(.IDX_W(3)) bus ();

   plan_select_sequencer #(.NUM_PLANS(5), .IDX_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.plan_price = tp[bus.plan_idx];
   assign bus.plan_talk  = tt[bus.plan_idx];
   assign bus.plan_data  = td[bus.plan_idx];
   assign bus.plan_vld   = !(bus.plan_req && (bus.plan_idx == stall_idx) && (stall_cnt < stall_len));

   always @(posedge clk) begin
      if (stall_clr)
         stall_cnt <= 0;
      else if (bus.plan_req && (bus.plan_idx == stall_idx) && (stall_cnt < stall_len))
         stall_cnt <= stall_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_plan(input int i, input logic [5:0] p, input logic [5:0] t, input logic [5:0] d);
      tp[i] = p;
      tt[i] = t;
      td[i] = d;
   endtask

   task automatic normal_setup();
      bus.budget   = 6'd30;
      bus.avg_talk = 6'd10;
      bus.avg_data = 6'd10;
      bus.w_talk   = 3'd2;
      bus.w_data   = 3'd3;
      set_plan(0, 6'd20, 6'd12, 6'd10);
      set_plan(1, 6'd25, 6'd20, 6'd15);
      set_plan(2, 6'd40, 6'd63, 6'd63);
      set_plan(3, 6'd10, 6'd5,  6'd50);
      set_plan(4, 6'd30, 6'd10, 6'd20);
   endtask

   // Pulses start, then waits (bounded) for done. cyc = cycle of done after the start cycle.
   // poke: at that cycle a second start is issued and budget forced to 0.
   task automatic run_scan(input int poke, output int cyc, output logic busy1, output int fetch2);
      logic [15:0] prev_score;
      logic [2:0]  prev_idx;
      logic        prev_none;
      bit          changed;
      prev_score = bus.best_score;
      prev_idx   = bus.best_idx;
      prev_none  = bus.none_ok;
      changed    = 1'b0;
      fetch2     = 0;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      cyc        = 1;
      busy1      = bus.busy;
      while ((bus.done !== 1'b1) && (cyc < 40)) begin
         if ((bus.best_score !== prev_score) || (bus.best_idx !== prev_idx) || (bus.none_ok !== prev_none))
            changed = 1'b1;
         if (bus.plan_req === 1'b1 && bus.plan_idx === 3'd2)
            fetch2++;
         if (cyc == poke) begin
            bus.start  = 1'b1;
            bus.budget = 6'd0;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         cyc++;
      end
      bus.start = 1'b0;
      checks++;
      if (changed) begin
         errors++;
         $display("FAIL results_hold_during_scan: results changed before done (now idx=%0d score=%0d none=%0d)",
                  bus.best_idx, bus.best_score, bus.none_ok);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.busy, bus.done, bus.plan_req, bus.plan_idx} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b done=%b req=%b idx=%0d, required all 0",
                  bus.busy, bus.done, bus.plan_req, bus.plan_idx);
      end
      checks++;
      if ({bus.best_idx, bus.best_score, bus.none_ok} !== 20'd0) begin
         errors++;
         $display("FAIL reset_results: idx=%0d score=%0d none=%b, required 0/0/0",
                  bus.best_idx, bus.best_score, bus.none_ok);
      end
   endtask

   task automatic test_normal();
      int cyc; logic b1; int f2;
      normal_setup();
      run_scan(-1, cyc, b1, f2);
      checks++;
      if (cyc != 11) begin errors++; $display("FAIL normal_latency: done at cycle %0d, required 11", cyc); end
      checks++;
      if (b1 !== 1'b1) begin errors++; $display("FAIL normal_busy: busy=%b after start, required 1", b1); end
      checks++;
      if ({bus.best_idx, bus.best_score, bus.none_ok} !== {3'd1, 16'd85, 1'b0}) begin
         errors++;
         $display("FAIL normal_result: idx=%0d score=%0d none=%b, required 1/85/0",
                  bus.best_idx, bus.best_score, bus.none_ok);
      end
      tick();
      checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         errors++;
         $display("FAIL done_pulse: done=%b busy=%b after done cycle, required 0/0", bus.done, bus.busy);
      end
   endtask

   task automatic test_tie();
      int cyc; logic b1; int f2;
      normal_setup();
      set_plan(0, 6'd30, 6'd10, 6'd20);
      set_plan(1, 6'd40, 6'd60, 6'd60);
      set_plan(2, 6'd5,  6'd5,  6'd5);
      set_plan(3, 6'd10, 6'd25, 6'd10);
      set_plan(4, 6'd31, 6'd60, 6'd60);
      run_scan(-1, cyc, b1, f2);
      checks++;
      if ({bus.best_idx, bus.best_score, bus.none_ok} !== {3'd0, 16'd80, 1'b0}) begin
         errors++;
         $display("FAIL tie_result: idx=%0d score=%0d none=%b, required 0/80/0",
                  bus.best_idx, bus.best_score, bus.none_ok);
      end
      tick();
   endtask

   task automatic test_fallback();
      int cyc; logic b1; int f2;
      normal_setup();
      bus.budget = 6'd5;
      set_plan(0, 6'd12, 6'd63, 6'd63);
      set_plan(1, 6'd9,  6'd63, 6'd63);
      set_plan(2, 6'd8,  6'd63, 6'd63);
      set_plan(3, 6'd8,  6'd63, 6'd63);
      set_plan(4, 6'd20, 6'd63, 6'd63);
      run_scan(-1, cyc, b1, f2);
      checks++;
      if ({bus.best_idx, bus.best_score, bus.none_ok} !== {3'd2, 16'd0, 1'b1}) begin
         errors++;
         $display("FAIL fallback_result: idx=%0d score=%0d none=%b, required 2/0/1",
                  bus.best_idx, bus.best_score, bus.none_ok);
      end
      tick();
   endtask

   task automatic test_stall();
      int cyc; logic b1; int f2;
      normal_setup();
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      stall_idx = 3'd2;
      stall_len = 3;
      run_scan(-1, cyc, b1, f2);
      checks++;
      if (cyc != 14) begin errors++; $display("FAIL stall_latency: done at cycle %0d, required 14", cyc); end
      checks++;
      if (f2 != 4) begin errors++; $display("FAIL stall_req_hold: plan 2 requested %0d cycles, required 4", f2); end
      checks++;
      if ({bus.best_idx, bus.best_score, bus.none_ok} !== {3'd1, 16'd85, 1'b0}) begin
         errors++;
         $display("FAIL stall_result: idx=%0d score=%0d none=%b, required 1/85/0",
                  bus.best_idx, bus.best_score, bus.none_ok);
      end
      stall_len = 0;
      stall_idx = 3'd7;
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc; logic b1; int f2;
      // Clear previous results so this scan's result is observable
      test_reset();
      normal_setup();
      run_scan(3, cyc, b1, f2);
      checks++;
      if (cyc != 11) begin errors++; $display("FAIL busy_start_latency: done at cycle %0d, required 11", cyc); end
      checks++;
      if ({bus.best_idx, bus.best_score, bus.none_ok} !== {3'd1, 16'd85, 1'b0}) begin
         errors++;
         $display("FAIL busy_start_result: idx=%0d score=%0d none=%b, required 1/85/0",
                  bus.best_idx, bus.best_score, bus.none_ok);
      end
      // start held through the DONE cycle (ignored) and the following IDLE cycle (accepted)
      bus.budget = 6'd30;
      bus.start  = 1'b1;
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_start_ignored: busy=%b, required 0", bus.busy); end
      run_scan(-1, cyc, b1, f2);
      checks++;
      if ((cyc != 11) || (b1 !== 1'b1)) begin
         errors++;
         $display("FAIL restart_after_done: done at cycle %0d busy=%b, required 11/1", cyc, b1);
      end
      checks++;
      if ({bus.best_idx, bus.best_score, bus.none_ok} !== {3'd1, 16'd85, 1'b0}) begin
         errors++;
         $display("FAIL restart_result: idx=%0d score=%0d none=%b, required 1/85/0",
                  bus.best_idx, bus.best_score, bus.none_ok);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int cyc; logic b1; int f2;
      normal_setup();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.busy, bus.plan_req, bus.plan_idx, bus.done, bus.best_idx, bus.best_score, bus.none_ok} !== 26'd0) begin
         errors++;
         $display("FAIL reset_mid_scan: busy=%b req=%b pidx=%0d done=%b idx=%0d score=%0d none=%b, required all 0",
                  bus.busy, bus.plan_req, bus.plan_idx, bus.done, bus.best_idx, bus.best_score, bus.none_ok);
      end
      run_scan(-1, cyc, b1, f2);
      checks++;
      if ((cyc != 11) || ({bus.best_idx, bus.best_score, bus.none_ok} !== {3'd1, 16'd85, 1'b0})) begin
         errors++;
         $display("FAIL post_reset_scan: cycle=%0d idx=%0d score=%0d none=%b, required 11/1/85/0",
                  cyc, bus.best_idx, bus.best_score, bus.none_ok);
      end
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) set_plan(i, 6'd63, 6'd0, 6'd0);
      normal_setup();
      test_reset();
      test_normal();
      test_tie();
      test_fallback();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
